// File: rtl/jt51_acc_mix.sv
// Frame mixer: sums carrier slots into L/R accumulators per pan, saturates once per frame; optional serial float DAC stream under JT51_ACC_SERIAL_EN.
// Latency: slot 31 reaches left/right two edges after it is presented; serial words start the cycle after the sample strobe.
// No backpressure: one slot is consumed every clk cycle unconditionally.
module jt51_acc_mix #(
  parameter int ACC_W = 19,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    zero,
  input  logic signed [13:0]      op_in,
  input  logic                    sum_en,
  input  logic        [1:0]       rl,
  output logic signed [OUT_W-1:0] left,
  output logic signed [OUT_W-1:0] right,
  output logic                    sample,
  output logic                    so,
  output logic                    ws
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W-1:0] acc_l, acc_r;
  logic signed [ACC_W-1:0] c_all, cl, cr;
  logic                    valid;

  always_comb begin
    c_all = '0;
    if (sum_en) c_all = {{(ACC_W-14){op_in[13]}}, op_in};
    cl = rl[0] ? c_all : '0;
    cr = rl[1] ? c_all : '0;
  end

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX) return SAT_MAX[OUT_W-1:0];
    if (a < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    return a[OUT_W-1:0];
  endfunction

  // The zero edge closes the old frame and seeds the new one with slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_l  <= '0;
      acc_r  <= '0;
      left   <= '0;
      right  <= '0;
      sample <= 1'b0;
      valid  <= 1'b0;
    end else if (zero) begin
      left   <= sat(acc_l);
      right  <= sat(acc_r);
      acc_l  <= cl;
      acc_r  <= cr;
      sample <= valid;
      valid  <= 1'b1;
    end else begin
      acc_l  <= acc_l + cl;
      acc_r  <= acc_r + cr;
      sample <= 1'b0;
    end
  end

`ifdef JT51_ACC_SERIAL_EN
  logic [31:0] sh;
  logic [4:0]  cnt;
  logic        busy;
  logic [15:0] wl, wr;

  // Smallest exponent whose range holds the value; mantissa truncated by arithmetic shift.
  function automatic logic [15:0] to_float(input logic signed [OUT_W-1:0] v);
    logic [2:0]              e;
    logic signed [OUT_W-1:0] m;
    int                      lim;
    e = 3'd7;
    for (int k = 7; k >= 1; k--) begin
      lim = 512 << (k - 1);
      if (int'(v) >= -lim && int'(v) < lim) e = 3'(k);
    end
    m = v >>> (e - 3'd1);
    return {e, m[9:0], 3'b000};
  endfunction

  always_comb begin
    wl = to_float(left);
    wr = to_float(right);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      so   <= 1'b0;
      ws   <= 1'b0;
    end else if (sample) begin
      so   <= wl[0];
      ws   <= 1'b0;
      sh   <= {1'b0, wr, wl[15:1]};
      cnt  <= 5'd1;
      busy <= 1'b1;
    end else if (busy) begin
      so   <= sh[0];
      ws   <= cnt[4];
      sh   <= {1'b0, sh[31:1]};
      cnt  <= cnt + 5'd1;
      busy <= (cnt != 5'd31);
    end else begin
      so <= 1'b0;
      ws <= 1'b0;
    end
  end
`else
  assign so = 1'b0;
  assign ws = 1'b0;
`endif

endmodule
